// File: rtl/filter_function_param.sv
// filter_function_param: MASK_WIDTH x MASK_WIDTH spatial filter with
// double-buffered coefficient banks; `define FILTER_SAT_EN to clamp q.
module filter_function_param #(
    parameter int PIX_BIT    = 8,
    parameter int MASK_WIDTH = 7,
    parameter int COFCNT_BIT = 16,
    parameter int FRAC_BIT   = 14
) (
    input  logic                                        clk,
    input  logic                                        reset_in,
    input  logic                                        enable,
    input  logic [PIX_BIT*MASK_WIDTH*MASK_WIDTH-1:0]    p,
    input  logic [COFCNT_BIT*MASK_WIDTH*MASK_WIDTH-1:0] c_in,
    input  logic                                        c_load,
    input  logic                                        c_swap,
    input  logic                                        sat_clr,
    output logic signed [PIX_BIT:0]                     q,
    output logic                                        ready,
    output logic                                        sat_flag
);

    localparam int N   = MASK_WIDTH * MASK_WIDTH;
    localparam int L   = $clog2(N);
    localparam int LAT = 3 + L;
    localparam int PW  = PIX_BIT + COFCNT_BIT + 1;
    localparam int SW  = PW + L;
    localparam int RW  = SW + 1;

    localparam logic signed [RW-1:0] RND = RW'((2 ** FRAC_BIT) / 2);

    function automatic int cnt(input int l);
        if (l <= 0) return N;
        return (N + (1 << l) - 1) >> l;
    endfunction

    logic [COFCNT_BIT*N-1:0] shadow;
    logic [COFCNT_BIT*N-1:0] active;
    logic [PIX_BIT*N-1:0]    p_r;
    logic [LAT-1:0]          vpipe;

    // load+swap together writes c_in straight through to both banks
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (c_load) shadow <= c_in;
            if (c_swap) active <= c_load ? c_in : shadow;
        end
    end

    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            p_r   <= '0;
            vpipe <= '0;
        end else begin
            p_r   <= p;
            vpipe <= {vpipe[LAT-2:0], enable};
        end
    end

    assign ready = vpipe[LAT-1];

    // level 0 holds the products; level g pairs up level g-1,
    // an odd leftover at the end of a level is just delayed
    for (genvar g = 0; g <= L; g++) begin : lv
        for (genvar j = 0; j < cnt(g); j++) begin : e
            logic signed [SW-1:0] v;
            if (g == 0) begin : m
                logic signed [PW-1:0] prod;
                assign prod =
                    $signed({1'b0, p_r[j*PIX_BIT +: PIX_BIT]}) *
                    $signed(active[j*COFCNT_BIT +: COFCNT_BIT]);
                always_ff @(posedge clk or posedge reset_in) begin
                    if (reset_in) v <= '0;
                    else          v <= {{L{prod[PW-1]}}, prod};
                end
            end else if (2*j+1 < cnt(g-1)) begin : a
                always_ff @(posedge clk or posedge reset_in) begin
                    if (reset_in) v <= '0;
                    else          v <= lv[g-1].e[2*j].v + lv[g-1].e[2*j+1].v;
                end
            end else begin : d
                always_ff @(posedge clk or posedge reset_in) begin
                    if (reset_in) v <= '0;
                    else          v <= lv[g-1].e[2*j].v;
                end
            end
        end
    end

    logic signed [SW-1:0] sum;
    logic signed [RW-1:0] rnd;
    logic signed [RW-1:0] r;

    assign sum = lv[L].e[0].v;

    // one guard bit so the rounding add cannot overflow
    always_comb begin
        rnd = {sum[SW-1], sum} + RND;
        r   = rnd >>> FRAC_BIT;
    end

`ifdef FILTER_SAT_EN
    localparam logic signed [RW-1:0] QMAX = RW'((2 ** PIX_BIT) - 1);
    localparam logic signed [RW-1:0] QMIN = RW'(-(2 ** PIX_BIT));

    logic hi;
    logic lo;

    assign hi = r > QMAX;
    assign lo = r < QMIN;

    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            q        <= '0;
            sat_flag <= 1'b0;
        end else begin
            if (hi)      q <= QMAX[PIX_BIT:0];
            else if (lo) q <= QMIN[PIX_BIT:0];
            else         q <= r[PIX_BIT:0];
            if (vpipe[LAT-2] && (hi || lo)) sat_flag <= 1'b1;
            else if (sat_clr)               sat_flag <= 1'b0;
        end
    end
`else
    logic unused_nosat;

    assign unused_nosat = ^{sat_clr, r[RW-1:PIX_BIT+1]};
    assign sat_flag     = 1'b0;

    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) q <= '0;
        else          q <= r[PIX_BIT:0];
    end
`endif

endmodule

// File: tb/tb_filter_function_param.sv
// tb_filter_function_param: random and directed stimulus against a
// cycle-indexed arithmetic model of the 7x7 filter.
module tb_filter_function_param;

    localparam int PB   = 8;
    localparam int MW   = 7;
    localparam int CB   = 16;
    localparam int FB   = 14;
    localparam int N    = MW * MW;
    localparam int LAT  = 3 + $clog2(N);
    localparam int MAXC = 4000;

    logic          clk = 1'b0;
    logic          reset_in = 1'b1;
    logic          enable;
    logic [PB*N-1:0] p;
    logic [CB*N-1:0] c_in;
    logic          c_load;
    logic          c_swap;
    logic          sat_clr;
    logic [PB:0]   q;
    logic          ready;
    logic          sat_flag;

    filter_function_param #(
        .PIX_BIT(PB), .MASK_WIDTH(MW), .COFCNT_BIT(CB), .FRAC_BIT(FB)
    ) dut (
        .clk(clk), .reset_in(reset_in), .enable(enable), .p(p),
        .c_in(c_in), .c_load(c_load), .c_swap(c_swap),
        .sat_clr(sat_clr), .q(q), .ready(ready), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    bit          exp_v [MAXC];
    logic [PB:0] exp_q [MAXC];
    bit          exp_s [MAXC];
    bit          clr_at[MAXC];
    bit          rst_at[MAXC];
    int          shadow_m[N];
    int          active_m[N];
    bit          sat_m = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h",
                     nm, cyc, act, req);
        end
    endtask

    // compare process: outputs seen just after edge cyc
    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        if (cyc < MAXC) begin
            if (rst_at[cyc]) sat_m = 1'b0;
            else sat_m = (exp_v[cyc] && exp_s[cyc]) || (sat_m && !clr_at[cyc]);
            chk("ready", ready, exp_v[cyc]);
            if (exp_v[cyc]) chk("q", q, exp_q[cyc]);
            chk("sat_flag", sat_flag, sat_m);
        end
    end

    task automatic drive(input bit en, input logic [PB*N-1:0] pv,
                         input logic [CB*N-1:0] cv, input bit ld,
                         input bit sw, input bit clr);
        int n;
        int cin[N];
        longint s;
        longint r;
        logic [63:0] rr;
        bit sat;
        n = cyc;
        enable = en; p = pv; c_in = cv;
        c_load = ld; c_swap = sw; sat_clr = clr;
        for (int i = 0; i < N; i++) cin[i] = $signed(cv[i*CB +: CB]);
        if (sw) for (int i = 0; i < N; i++) active_m[i] = ld ? cin[i] : shadow_m[i];
        if (ld) for (int i = 0; i < N; i++) shadow_m[i] = cin[i];
        if (n + LAT < MAXC) begin
            clr_at[n+1] = clr;
            if (en) begin
                s = 0;
                for (int i = 0; i < N; i++)
                    s += longint'(pv[i*PB +: PB]) * longint'(active_m[i]);
                r = (s + (64'sd1 << (FB - 1))) >>> FB;
                sat = 1'b0;
`ifdef FILTER_SAT_EN
                if (r > 255) begin r = 255; sat = 1'b1; end
                else if (r < -256) begin r = -256; sat = 1'b1; end
`endif
                rr = r;
                exp_v[n+LAT] = 1'b1;
                exp_q[n+LAT] = rr[PB:0];
                exp_s[n+LAT] = sat;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        int n;
        n = cyc;
        reset_in = 1'b1;
        enable = 1'b0; c_load = 1'b0; c_swap = 1'b0; sat_clr = 1'b0;
        #1;
        chk("rst_async_ready", ready, 0);
        chk("rst_async_q", q, 0);
        chk("rst_async_sat", sat_flag, 0);
        for (int m = n + 1; m <= n + LAT && m < MAXC; m++) exp_v[m] = 1'b0;
        if (n + 1 < MAXC) begin
            rst_at[n+1] = 1'b1;
            clr_at[n+1] = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            shadow_m[i] = 0;
            active_m[i] = 0;
        end
        @(negedge clk);
        reset_in = 1'b0;
    endtask

    function automatic logic [PB*N-1:0] pix_center(input int v);
        logic [PB*N-1:0] x;
        x = '0;
        x[24*PB +: PB] = PB'(v);
        return x;
    endfunction

    function automatic logic [PB*N-1:0] pix_all(input int v);
        logic [PB*N-1:0] x;
        for (int i = 0; i < N; i++) x[i*PB +: PB] = PB'(v);
        return x;
    endfunction

    function automatic logic [CB*N-1:0] coef_center(input int v);
        logic [CB*N-1:0] x;
        x = '0;
        x[24*CB +: CB] = CB'(v);
        return x;
    endfunction

    function automatic logic [CB*N-1:0] coef_all(input int v);
        logic [CB*N-1:0] x;
        for (int i = 0; i < N; i++) x[i*CB +: CB] = CB'(v);
        return x;
    endfunction

    function automatic logic [PB*N-1:0] pix_rand();
        logic [PB*N-1:0] x;
        for (int i = 0; i < N; i++) x[i*PB +: PB] = PB'($urandom);
        return x;
    endfunction

    function automatic logic [CB*N-1:0] coef_rand(input int mode);
        logic [CB*N-1:0] x;
        x = '0;
        for (int i = 0; i < N; i++) begin
            if (mode == 0)      x[i*CB +: CB] = CB'($urandom_range(0, 1200) - 600);
            else if (mode == 1) x[i*CB +: CB] = CB'($urandom);
        end
        if (mode == 2) x[24*CB +: CB] = CB'($urandom_range(0, 40000) - 20000);
        return x;
    endfunction

    // one window, then literal checks on the exact ready cycle
    task automatic single(input string nm, input logic [PB*N-1:0] pv,
                          input logic [CB*N-1:0] cv, input bit lsw,
                          input logic [PB:0] want, input bit want_s);
        int n0;
        n0 = cyc;
        drive(1'b1, pv, cv, lsw, lsw, 1'b0);
        while (cyc < n0 + LAT + 1) begin
            if (cyc == n0 + LAT - 1) chk({nm, "_early"}, ready, 0);
            if (cyc == n0 + LAT) begin
                chk({nm, "_rdy"}, ready, 1);
                chk({nm, "_q"}, q, want);
                chk({nm, "_sat"}, sat_flag, want_s);
            end
            idle();
        end
        chk({nm, "_late"}, ready, 0);
    endtask

    logic [PB:0] sat_q;
    bit          sat_s;

    initial begin
        enable = 1'b0; p = '0; c_in = '0;
        c_load = 1'b0; c_swap = 1'b0; sat_clr = 1'b0;
        rst_at[1] = 1'b1;
        @(negedge clk);
        reset_in = 1'b0;
        chk("reset_ready", ready, 0);
        chk("reset_q", q, 0);
        chk("reset_sat", sat_flag, 0);
        idle();

        single("center200", pix_center(200), coef_center(16384), 1'b1, 9'd200, 1'b0);
        single("neg100", pix_center(100), coef_center(-16384), 1'b1, 9'h19C, 1'b0);

        // stream 100s; new bank loaded at window 3, swapped in at window 6
        drive(1'b0, '0, coef_center(16384), 1'b1, 1'b1, 1'b0);
        begin
            int n0;
            n0 = cyc;
            for (int k = 0; k <= LAT + 10; k++) begin
                if (k >= LAT && k < LAT + 10) begin
                    chk("swap_rdy", ready, 1);
                    chk("swap_q", q, (k - LAT < 6) ? 9'd100 : 9'd50);
                end
                if (k == LAT + 10) chk("swap_end", ready, 0);
                if (k < 10)
                    drive(1'b1, pix_center(100), coef_center(8192),
                          k == 3, k == 6, 1'b0);
                else
                    idle();
            end
        end

`ifdef FILTER_SAT_EN
        sat_q = 9'd255; sat_s = 1'b1;
`else
        sat_q = 9'd207; sat_s = 1'b0;
`endif
        single("sat", pix_all(255), coef_all(16384), 1'b1, sat_q, sat_s);
        idle(); idle();
        chk("sat_hold", sat_flag, sat_s);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        chk("sat_clr", sat_flag, 0);

        for (int k = 0; k < 14; k++) drive(1'b1, pix_all(255), '0, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_rdy", ready, 1);
        chk("pre_rst_q", q, sat_q);
        do_reset();
        for (int k = 0; k < LAT + 2; k++) idle();
        single("post_rst", pix_center(100), '0, 1'b0, 9'd0, 1'b0);

        for (int it = 0; it < 1500; it++) begin
            if (it == 700) do_reset();
            drive($urandom_range(0, 9) < 7, pix_rand(),
                  coef_rand($urandom_range(0, 2)),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 19) == 0);
        end
        for (int k = 0; k < LAT + 2; k++) idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
